// File: rtl/collision_sweep_controller_if.sv
// Collision CI bus plus the result stream; master = sweep controller, slave = CI unit and result consumer.
interface collision_sweep_controller_if #(
  parameter int WORD_SIZE = 32,
  parameter int TARGET_W  = 5
);
  logic                 res_valid;
  logic                 res_ready;
  logic [TARGET_W-1:0]  res_target;
  logic [WORD_SIZE-1:0] res_data;
  logic                 ci_clk_en;
  logic                 ci_reset;
  logic                 ci_start;
  logic [WORD_SIZE-1:0] ci_dataa;
  logic [WORD_SIZE-1:0] ci_datab;
  logic                 ci_n;
  logic                 ci_done;
  logic [WORD_SIZE-1:0] ci_result;

  modport master (
    output res_valid, res_target, res_data,
    output ci_clk_en, ci_reset, ci_start, ci_dataa, ci_datab, ci_n,
    input  res_ready, ci_done, ci_result
  );

  modport slave (
    input  res_valid, res_target, res_data,
    input  ci_clk_en, ci_reset, ci_start, ci_dataa, ci_datab, ci_n,
    output res_ready, ci_done, ci_result
  );
endinterface

// File: rtl/collision_sweep_controller.sv
// Per target: MSG_WORDS/2 paired message loads then one search, each op a 1-cycle start strobe then wait for ci_done.
// Each result is held on res_valid until res_ready; no CI op is issued while a result is pending.
module collision_sweep_controller #(
  parameter int WORD_SIZE      = 32,
  parameter int MSG_WORDS      = 16,
  parameter int TARGET_W       = 5,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         msg_we,
  input  logic [$clog2(MSG_WORDS)-1:0] msg_addr,
  input  logic [WORD_SIZE-1:0]         msg_wdata,
  input  logic                         sweep_start,
  input  logic                         sweep_abort,
  input  logic [TARGET_W-1:0]          first_target,
  input  logic [TARGET_W-1:0]          last_target,
  output logic                         busy,
  output logic                         sweep_done,
  output logic                         sweep_err,
  collision_sweep_controller_if.master bus
);
  localparam int AW = $clog2(MSG_WORDS);
  localparam int KW = (AW > 1) ? AW - 1 : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [KW-1:0] LAST_K  = KW'(MSG_WORDS / 2 - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LD_ISSUE, LD_WAIT, SR_ISSUE, SR_WAIT, RES_OUT, GAP} state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] msg_q [MSG_WORDS];
  logic [KW-1:0]        k_q, k_d;
  logic                 sr_next_q, sr_next_d;
  logic [TARGET_W-1:0]  tgt_q, tgt_d, last_q, last_d, res_tgt_q, res_tgt_d;
  logic [WORD_SIZE-1:0] res_dat_q, res_dat_d, dataa_q, dataa_d, datab_q, datab_d;
  logic                 n_q, n_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d, err_q, err_d, kill_q, kill_d;
  logic                 timeout;
  logic [AW-1:0]        addr_even, addr_odd;

  // Message store is frozen outside IDLE so every target of a sweep sees the same block.
  always_ff @(posedge clk) begin
    if (msg_we && state_q == IDLE) msg_q[msg_addr] <= msg_wdata;
  end

  assign addr_even = AW'({k_d, 1'b0});
  assign addr_odd  = AW'({k_d, 1'b1});

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    sr_next_d = sr_next_q;
    tgt_d     = tgt_q;
    last_d    = last_q;
    res_tgt_d = res_tgt_q;
    res_dat_d = res_dat_q;
    dataa_d   = dataa_q;
    datab_d   = datab_q;
    n_d       = n_q;
    cnt_d     = '0;
    done_d    = 1'b0;
    err_d     = err_q;
    kill_d    = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sweep_start) begin
          tgt_d     = first_target;
          last_d    = last_target;
          k_d       = '0;
          sr_next_d = 1'b0;
          if (first_target > last_target) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            state_d = LD_ISSUE;
          end
        end
      end
      LD_ISSUE: state_d = LD_WAIT;
      SR_ISSUE: state_d = SR_WAIT;
      LD_WAIT: begin
        if (bus.ci_done) begin
          state_d = GAP;
          if (k_q == LAST_K) sr_next_d = 1'b1;
          else               k_d = k_q + 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          timeout = (cnt_q == CNT_MAX);
        end
      end
      SR_WAIT: begin
        if (bus.ci_done) begin
          res_dat_d = bus.ci_result;
          res_tgt_d = tgt_q;
          state_d   = RES_OUT;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          timeout = (cnt_q == CNT_MAX);
        end
      end
      GAP: state_d = sr_next_q ? SR_ISSUE : LD_ISSUE;
      RES_OUT: begin
        if (bus.res_ready) begin
          if (tgt_q == last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tgt_d     = tgt_q + 1'b1;
            k_d       = '0;
            sr_next_d = 1'b0;
            state_d   = GAP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort and timeout override any completion or handshake seen in the same cycle.
    if (state_q != IDLE && (sweep_abort || timeout)) begin
      state_d = IDLE;
      done_d  = 1'b1;
      err_d   = 1'b1;
      kill_d  = 1'b1;
    end
    if (state_d == LD_ISSUE) begin
      n_d     = 1'b0;
      dataa_d = msg_q[addr_even];
      datab_d = msg_q[addr_odd];
    end else if (state_d == SR_ISSUE) begin
      n_d     = 1'b1;
      dataa_d = WORD_SIZE'(tgt_d);
      datab_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      sr_next_q <= 1'b0;
      tgt_q     <= '0;
      last_q    <= '0;
      res_tgt_q <= '0;
      res_dat_q <= '0;
      dataa_q   <= '0;
      datab_q   <= '0;
      n_q       <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      sr_next_q <= sr_next_d;
      tgt_q     <= tgt_d;
      last_q    <= last_d;
      res_tgt_q <= res_tgt_d;
      res_dat_q <= res_dat_d;
      dataa_q   <= dataa_d;
      datab_q   <= datab_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      kill_q    <= kill_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign sweep_done     = done_q;
  assign sweep_err      = err_q;
  assign bus.res_valid  = (state_q == RES_OUT);
  assign bus.res_target = res_tgt_q;
  assign bus.res_data   = res_dat_q;
  assign bus.ci_clk_en  = 1'b1;
  assign bus.ci_reset   = reset | kill_q;
  assign bus.ci_start   = (state_q == LD_ISSUE) || (state_q == SR_ISSUE);
  assign bus.ci_dataa   = dataa_q;
  assign bus.ci_datab   = datab_q;
  assign bus.ci_n       = n_q;
endmodule

// File: tb/tb_collision_sweep_controller.sv
// Randomized bench: stub CI unit, per-sweep expected op/result queues built from the message and target range.
module tb_collision_sweep_controller;
  localparam int WS = 32;
  localparam int MW = 16;
  localparam int TW = 5;
  localparam int TO = 64;

  typedef struct packed {
    logic          n;
    logic [WS-1:0] a;
    logic [WS-1:0] b;
  } op_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          msg_we = 1'b0;
  logic [3:0]    msg_addr = '0;
  logic [WS-1:0] msg_wdata = '0;
  logic          sweep_start = 1'b0;
  logic          sweep_abort = 1'b0;
  logic [TW-1:0] first_target = '0;
  logic [TW-1:0] last_target = '0;
  logic          busy, sweep_done, sweep_err;

  collision_sweep_controller_if #(.WORD_SIZE(WS), .TARGET_W(TW)) bus();

  collision_sweep_controller #(
    .WORD_SIZE(WS), .MSG_WORDS(MW), .TARGET_W(TW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .msg_we(msg_we), .msg_addr(msg_addr), .msg_wdata(msg_wdata),
    .sweep_start(sweep_start), .sweep_abort(sweep_abort),
    .first_target(first_target), .last_target(last_target),
    .busy(busy), .sweep_done(sweep_done), .sweep_err(sweep_err), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_starts = 0, n_done = 0, n_kill = 0, n_results = 0;
  int done_cyc = -100, hs_cyc = 0, last_start_cyc = 0, kill_cyc = 0;
  bit hs_pending = 0;
  logic [WS-1:0] msg [MW];
  op_t           exp_ops [$];
  logic [TW-1:0] exp_tgt [$];
  logic [WS-1:0] exp_dat [$];
  logic [TW-1:0] cur_last = '0;

  int delay = 4;
  bit rand_delay = 0, hold = 0, hang = 0, hang_search = 0, abort_on_done = 0, fixed_en = 0, garble = 0;
  logic [WS-1:0] fixed_val = 32'hDEADBEEF;
  int ready_mode = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_msg;
    for (int i = 0; i < MW; i++) begin
      msg_we = 1'b1; msg_addr = 4'(i); msg_wdata = msg[i];
      tick;
    end
    msg_we = 1'b0;
  endtask

  task automatic random_msg;
    for (int i = 0; i < MW; i++) msg[i] = $urandom;
    write_msg;
  endtask

  // Reference: every target reloads all word pairs in order, then searches with the target index.
  task automatic build_model(input logic [TW-1:0] f, input logic [TW-1:0] l);
    exp_ops.delete(); exp_tgt.delete(); exp_dat.delete();
    hs_pending = 0;
    cur_last = l;
    for (int t = int'(f); t <= int'(l); t++) begin
      for (int k = 0; k < MW / 2; k++) exp_ops.push_back({1'b0, msg[2*k], msg[2*k+1]});
      exp_ops.push_back({1'b1, 32'(t), 32'h0});
      exp_tgt.push_back(5'(t));
    end
  endtask

  task automatic pulse_start(input logic [TW-1:0] f, input logic [TW-1:0] l);
    first_target = f; last_target = l; sweep_start = 1'b1;
    tick;
    sweep_start = 1'b0;
  endtask

  task automatic run_sweep(input logic [TW-1:0] f, input logic [TW-1:0] l, input int budget);
    int d0, s0, r0, b, nt;
    d0 = n_done; s0 = n_starts; r0 = n_results;
    nt = (f <= l) ? int'(l) - int'(f) + 1 : 0;
    build_model(f, l);
    pulse_start(f, l);
    b = budget;
    while (n_done == d0 && b > 0) begin
      if (garble && busy) begin
        msg_we = $urandom_range(0, 1); msg_addr = 4'($urandom); msg_wdata = $urandom;
      end else msg_we = 1'b0;
      tick;
      b--;
    end
    msg_we = 1'b0;
    chk("sweep_done_seen", n_done - d0, 1);
    tick; tick;
    chk("sweep_err", sweep_err, f > l);
    chk("busy_after_sweep", busy, 0);
    chk("ops_left", exp_ops.size(), 0);
    chk("result_count", n_results - r0, nt);
    chk("ci_start_count", n_starts - s0, nt * (MW / 2 + 1));
    chk("sweep_done_once", n_done - d0, 1);
  endtask

  // Stub CI: done after 'delay' cycles, optionally held high until the next start.
  initial begin
    bit outst, is_search, abort_fired;
    int cd;
    outst = 0; is_search = 0; abort_fired = 0; cd = 0;
    bus.ci_done = 1'b0; bus.ci_result = '0;
    forever begin
      tick;
      if (abort_fired) begin sweep_abort = 1'b0; abort_fired = 0; end
      if (bus.ci_reset) begin
        bus.ci_done = 1'b0; outst = 0;
      end else if (bus.ci_start) begin
        bus.ci_done = 1'b0; outst = 1; is_search = bus.ci_n;
        cd = rand_delay ? $urandom_range(1, 6) : delay;
      end else if (outst) begin
        if (cd > 1) cd--;
        else if (!hang && !(hang_search && is_search)) begin
          bus.ci_done = 1'b1; outst = 0; done_cyc = cyc + 1;
          bus.ci_result = fixed_en ? fixed_val : $urandom;
          if (is_search) exp_dat.push_back(bus.ci_result);
          if (abort_on_done) begin sweep_abort = 1'b1; abort_fired = 1; abort_on_done = 0; end
        end
      end else if (!hold) bus.ci_done = 1'b0;
    end
  end

  initial begin
    int vcnt;
    vcnt = 0;
    bus.res_ready = 1'b0;
    forever begin
      tick;
      case (ready_mode)
        0: bus.res_ready = 1'b1;
        1: bus.res_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (bus.res_valid) begin bus.res_ready = (vcnt >= 10); vcnt++; end
          else begin bus.res_ready = 1'b0; vcnt = 0; end
        end
      endcase
    end
  end

  initial begin
    logic          pv, kp;
    logic [WS-1:0] pd, ed;
    logic [TW-1:0] pt, et;
    op_t           op;
    pv = 0; kp = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        pv = 0; kp = 0;
      end else begin
        if (bus.ci_reset) begin
          if (!kp) kill_cyc = cyc;
          n_kill++;
        end
        kp = bus.ci_reset;
        if (sweep_done) n_done++;
        if (bus.ci_start) begin
          n_starts++;
          last_start_cyc = cyc;
          chk("start_expected", exp_ops.size() > 0, 1);
          if (exp_ops.size() > 0) begin
            op = exp_ops.pop_front();
            chk("ci_n", bus.ci_n, op.n);
            chk("ci_dataa", bus.ci_dataa, op.a);
            chk("ci_datab", bus.ci_datab, op.b);
          end
          chk("start_while_valid", bus.res_valid, 0);
          chk("start_gap", (cyc - done_cyc) >= 2, 1);
          if (hs_pending) begin
            chk("resume_after_handshake", cyc - hs_cyc, 2);
            hs_pending = 0;
          end
        end
        if (pv) begin
          chk("stall_valid_held", bus.res_valid, 1);
          chk("stall_data_stable", bus.res_data, pd);
          chk("stall_target_stable", bus.res_target, pt);
        end
        if (bus.res_valid && bus.res_ready) begin
          n_results++;
          chk("result_expected", (exp_tgt.size() > 0) && (exp_dat.size() > 0), 1);
          if (exp_tgt.size() > 0) begin et = exp_tgt.pop_front(); chk("res_target", bus.res_target, et); end
          if (exp_dat.size() > 0) begin ed = exp_dat.pop_front(); chk("res_data", bus.res_data, ed); end
          if (bus.res_target != cur_last) begin hs_pending = 1; hs_cyc = cyc; end
        end
        pv = bus.res_valid && !bus.res_ready;
        pd = bus.res_data;
        pt = bus.res_target;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    string s;
    logic [7:0] by [4*MW];
    int d0, s0, k0, r0, b;

    repeat (3) tick;
    chk("rst_busy", busy, 0);
    chk("rst_sweep_done", sweep_done, 0);
    chk("rst_sweep_err", sweep_err, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_target", bus.res_target, 0);
    chk("rst_ci_start", bus.ci_start, 0);
    chk("rst_ci_n", bus.ci_n, 0);
    chk("rst_ci_dataa", bus.ci_dataa, 0);
    chk("rst_ci_datab", bus.ci_datab, 0);
    chk("rst_ci_reset", bus.ci_reset, 1);
    chk("ci_clk_en", bus.ci_clk_en, 1);
    reset = 1'b0;
    tick;
    chk("ci_reset_released", bus.ci_reset, 0);

    // Single target with the padded text block.
    s = "XXXX Keep your FPGA spinning!";
    for (int i = 0; i < 4 * MW; i++) by[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) by[i] = s[i];
    by[s.len()] = 8'h80;
    for (int i = 0; i < MW; i++) msg[i] = {by[4*i], by[4*i+1], by[4*i+2], by[4*i+3]};
    msg[MW-1] = 32'h0000_0180;
    write_msg;
    delay = 4; fixed_en = 1; ready_mode = 0;
    run_sweep(5'd3, 5'd3, 500);
    chk("single_res_data", bus.res_data, 32'hDEADBEEF);
    chk("single_res_target", bus.res_target, 3);
    fixed_en = 0;

    // Full range, consumer always ready.
    random_msg;
    rand_delay = 1;
    run_sweep(5'd0, 5'd31, 20000);

    // Consumer stalls 10 cycles on every result.
    ready_mode = 2;
    run_sweep(5'd10, 5'd12, 3000);

    // Random ranges, random readiness, level-held done, message writes during the sweep.
    ready_mode = 1; garble = 1;
    for (int i = 0; i < 5; i++) begin
      logic [TW-1:0] f, l;
      random_msg;
      hold = $urandom_range(0, 1);
      f = 5'($urandom_range(0, 31));
      l = (int'(f) + 3 > 31) ? 5'd31 : f + 5'($urandom_range(0, 3));
      run_sweep(f, l, 5000);
    end
    run_sweep(5'd30, 5'd31, 3000);
    garble = 0; hold = 0; ready_mode = 0;

    // Inverted range.
    run_sweep(5'd5, 5'd2, 3);

    // Timeout while waiting on a load.
    hang = 1;
    d0 = n_done; s0 = n_starts; k0 = n_kill;
    build_model(5'd0, 5'd0);
    pulse_start(5'd0, 5'd0);
    b = 300;
    while (n_kill == k0 && b > 0) begin tick; b--; end
    chk("timeout_reset_seen", n_kill > k0, 1);
    chk("timeout_latency", kill_cyc - last_start_cyc, TO + 1);
    tick; tick;
    chk("timeout_ci_reset_width", n_kill - k0, 1);
    chk("timeout_err", sweep_err, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_done", n_done - d0, 1);
    chk("timeout_starts", n_starts - s0, 1);
    hang = 0;
    run_sweep(5'd2, 5'd2, 500);

    // Abort in the same cycle as the first load's ci_done.
    random_msg;
    d0 = n_done; s0 = n_starts; k0 = n_kill; r0 = n_results;
    build_model(5'd4, 5'd6);
    abort_on_done = 1;
    pulse_start(5'd4, 5'd6);
    b = 200;
    while (n_done == d0 && b > 0) begin tick; b--; end
    repeat (20) tick;
    chk("abort_done", n_done - d0, 1);
    chk("abort_err", sweep_err, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ci_reset", n_kill - k0, 1);
    chk("abort_starts", n_starts - s0, 1);
    chk("abort_results", n_results - r0, 0);

    // Reset while the search is outstanding.
    hang_search = 1;
    s0 = n_starts;
    build_model(5'd7, 5'd7);
    pulse_start(5'd7, 5'd7);
    b = 500;
    while (n_starts - s0 < MW / 2 + 1 && b > 0) begin tick; b--; end
    chk("sr_issued", n_starts - s0, MW / 2 + 1);
    chk("sr_is_search", bus.ci_n, 1);
    repeat (3) tick;
    reset = 1'b1;
    tick;
    chk("midrst_busy", busy, 0);
    chk("midrst_res_valid", bus.res_valid, 0);
    chk("midrst_ci_start", bus.ci_start, 0);
    chk("midrst_ci_reset", bus.ci_reset, 1);
    chk("midrst_sweep_done", sweep_done, 0);
    chk("midrst_sweep_err", sweep_err, 0);
    chk("midrst_ci_n", bus.ci_n, 0);
    chk("midrst_ci_dataa", bus.ci_dataa, 0);
    reset = 1'b0;
    hang_search = 0;
    d0 = n_done; r0 = n_results;
    repeat (30) tick;
    chk("midrst_no_result", n_results - r0, 0);
    chk("midrst_no_done", n_done - d0, 0);
    chk("midrst_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
